xor_parity_accum: RTL and testbench



---
 rtl/xor_parity_pkg.sv | 19 +
 rtl/xor_reduce.sv | 35 +++
 rtl/xor_parity_accum.sv | 146 ++++++++++++++
 tb/tb_xor_parity_accum.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xor_parity_pkg.sv
// -----------------------------------------------------------------------------
// xor_parity_pkg
// Shared definitions for the streaming XOR/parity engine.
//   state_t   : engine state (ACCUM collects words, DONE presents a result)
//   cnt_width : width of a word counter able to hold 0..max_words
// -----------------------------------------------------------------------------
package xor_parity_pkg;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    // Counter width that represents every value from 0 to max_words inclusive.
    function automatic int cnt_width(input int max_words);
        return $clog2(max_words + 1);
    endfunction

endpackage

// File: rtl/xor_reduce.sv
// -----------------------------------------------------------------------------
// xor_reduce
// Combinational WIDTH-bit reduction XOR: the N-input generalisation of the
// two-input XOR gate. Result is 1 when data holds an odd number of ones.
// Ports:
//   data   in  WIDTH  word to reduce
//   parity out 1      XOR of every bit of data
// -----------------------------------------------------------------------------
module xor_reduce #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    output logic             parity
);

    // Even-parity helper: XOR of all bits of v.
    function automatic logic reduce_xor(input logic [WIDTH-1:0] v);
        logic p;
        p = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            p = p ^ v[i];
        end
        return p;
    endfunction

    logic parity_s;

    // Reduce the word to a single parity bit.
    always_comb begin
        parity_s = reduce_xor(data);
    end

    assign parity = parity_s;

endmodule

// File: rtl/xor_parity_accum.sv
// -----------------------------------------------------------------------------
// xor_parity_accum
// Streaming XOR/parity engine. Accumulates the column-wise XOR of all words of
// a frame, then presents the result (word, parity, count, overflow flag) on a
// valid/ready handshake. A frame closes on in_last or when MAX_WORDS words have
// been accepted. No word is accepted while a result is waiting.
//
// Configuration macro: XOR_PARITY_ODD_EN
//   undefined : out_bit = ^out_word       (even parity)
//   defined   : out_bit = ~(^out_word)    (odd parity); reset value still 0
//
// Ports:
//   clk        in   1      system clock, rising edge
//   rst        in   1      synchronous active-high reset
//   in_valid   in   1      input word valid
//   in_ready   out  1      engine accepts a word this cycle
//   in_data    in   WIDTH  input word
//   in_last    in   1      last word of the frame
//   out_valid  out  1      result valid, held until accepted
//   out_ready  in   1      consumer accepts the result
//   out_word   out  WIDTH  column XOR of the frame
//   out_bit    out  1      frame parity
//   out_count  out  CNT_W  number of words in the frame
//   out_ovf    out  1      frame force-closed at MAX_WORDS without in_last
// -----------------------------------------------------------------------------
module xor_parity_accum
    import xor_parity_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_WORDS = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   in_data,
    input  logic                               in_last,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [WIDTH-1:0]                   out_word,
    output logic                               out_bit,
    output logic [cnt_width(MAX_WORDS)-1:0]    out_count,
    output logic                               out_ovf
);

    localparam int               CNT_W   = cnt_width(MAX_WORDS);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    state_t             state_r;
    logic [WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [WIDTH-1:0]   out_word_r;
    logic               out_bit_r;
    logic [CNT_W-1:0]   out_count_r;
    logic               out_ovf_r;

    logic               accept_s;
    logic [WIDTH-1:0]   word_next_s;
    logic [CNT_W-1:0]   cnt_next_s;
    logic               at_max_s;
    logic               close_s;
    logic               red_s;
    logic               par_s;

    assign accept_s    = in_valid & in_ready_r;
    assign word_next_s = acc_r ^ in_data;
    assign cnt_next_s  = cnt_r + CNT_W'(1);
    assign at_max_s    = (cnt_next_s == MAX_CNT);
    assign close_s     = in_last | at_max_s;

    // Parity of the word that would be loaded into the result register, so
    // out_bit is registered on the same edge as out_word.
    xor_reduce #(
        .WIDTH (WIDTH)
    ) u_xor_reduce (
        .data   (word_next_s),
        .parity (red_s)
    );

`ifdef XOR_PARITY_ODD_EN
    assign par_s = ~red_s;
`else
    assign par_s = red_s;
`endif

    // Frame FSM: accumulate in ACCUM, hold the result in DONE until accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ACCUM;
            acc_r       <= '0;
            cnt_r       <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_word_r  <= '0;
            out_bit_r   <= 1'b0;
            out_count_r <= '0;
            out_ovf_r   <= 1'b0;
        end else begin
            case (state_r)
                ACCUM: begin
                    if (accept_s) begin
                        if (close_s) begin
                            // in_last wins over the limit: ovf only on a forced close.
                            out_word_r  <= word_next_s;
                            out_bit_r   <= par_s;
                            out_count_r <= cnt_next_s;
                            out_ovf_r   <= ~in_last & at_max_s;
                            out_valid_r <= 1'b1;
                            in_ready_r  <= 1'b0;
                            state_r     <= DONE;
                        end else begin
                            acc_r <= word_next_s;
                            cnt_r <= cnt_next_s;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        acc_r       <= '0;
                        cnt_r       <= '0;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= ACCUM;
                    end
                end
                default: begin
                    acc_r       <= '0;
                    cnt_r       <= '0;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    state_r     <= ACCUM;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_word  = out_word_r;
    assign out_bit   = out_bit_r;
    assign out_count = out_count_r;
    assign out_ovf   = out_ovf_r;

endmodule

// File: tb/tb_xor_parity_accum.sv
// -----------------------------------------------------------------------------
// tb_xor_parity_accum
// Scoreboard bench for xor_parity_accum (WIDTH=8, MAX_WORDS=16). The driver
// feeds words through a frame model that pushes expected results into a queue;
// a monitor pops and compares whenever the engine presents a result.
// -----------------------------------------------------------------------------
module tb_xor_parity_accum;

    localparam int WIDTH = 8;
    localparam int MAXW  = 16;

    typedef struct {
        logic [7:0] word;
        logic       pbit;
        int         count;
        logic       ovf;
    } res_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_word;
    logic       out_bit;
    logic [4:0] out_count;
    logic       out_ovf;

    int checks = 0;
    int fails  = 0;
    int rdy_mode = 0;     // 0: always ready, 1: random, 2: never ready

    res_t exp_q[$];

    // Reference model: running XOR and word count of the current frame.
    logic [7:0] m_acc;
    int         m_n;

    xor_parity_accum #(
        .WIDTH     (WIDTH),
        .MAX_WORDS (MAXW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_bit   (out_bit),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic exp_parity(input logic [7:0] w);
        int ones;
        ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(w[i]);
`ifdef XOR_PARITY_ODD_EN
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
`else
        return (ones % 2 == 1) ? 1'b1 : 1'b0;
`endif
    endfunction

    // One accepted word enters the frame model; returns 1 if it closed a frame.
    function automatic logic model_accept(input logic [7:0] d, input logic l);
        res_t r;
        m_acc = m_acc ^ d;
        m_n   = m_n + 1;
        if (l || m_n == MAXW) begin
            r.word  = m_acc;
            r.pbit  = exp_parity(m_acc);
            r.count = m_n;
            r.ovf   = (!l && m_n == MAXW);
            exp_q.push_back(r);
            m_acc = 8'h00;
            m_n   = 0;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // Idle cycles with junk on the data lines, which must be ignored.
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_data  = 8'($urandom);
            in_last  = 1'($urandom);
        end
    endtask

    // Present one word and hold it until the engine takes it.
    task automatic send(input logic [7:0] d, input logic l, input int gap);
        int   waitc;
        logic closed;
        if (gap > 0) idle(gap);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        waitc = 0;
        while (!in_ready && waitc < 300) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
        end else begin
            closed = model_accept(d, l);
            @(posedge clk);
            #1;
            if (closed) chk("close_latency", int'(out_valid), 1);
        end
    endtask

    // Wait for every expected result to be consumed.
    task automatic drain();
        int c;
        c = 0;
        while ((exp_q.size() != 0 || out_valid) && c < 2000) begin
            @(negedge clk);
            c++;
        end
        if (exp_q.size() != 0 || out_valid) chk("drain_timeout", 0, 1);
    endtask

    // Consumer: drive out_ready shortly after each rising edge.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 2) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: compare each presented result once, then check it stays put.
    initial begin
        res_t e;
        logic held;
        logic [7:0] h_word;
        logic h_bit;
        logic [4:0] h_cnt;
        logic h_ovf;
        held = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                held = 1'b0;
            end else if (out_valid) begin
                chk("in_ready_low_in_done", int'(in_ready), 0);
                if (!held) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_word", int'(out_word), int'(e.word));
                        chk("out_bit", int'(out_bit), int'(e.pbit));
                        chk("out_count", int'(out_count), e.count);
                        chk("out_ovf", int'(out_ovf), int'(e.ovf));
                    end
                    held   = 1'b1;
                    h_word = out_word;
                    h_bit  = out_bit;
                    h_cnt  = out_count;
                    h_ovf  = out_ovf;
                end else begin
                    chk("hold_stable", int'({out_word, out_bit, out_count, out_ovf}),
                        int'({h_word, h_bit, h_cnt, h_ovf}));
                end
                if (out_ready) held = 1'b0;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        m_acc    = 8'h00;
        m_n      = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        // Reset state, first cycle after release.
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_word", int'(out_word), 0);
        chk("rst_out_bit", int'(out_bit), 0);
        chk("rst_out_count", int'(out_count), 0);
        chk("rst_out_ovf", int'(out_ovf), 0);

        // Two-word frame.
        rdy_mode = 0;
        send(8'hA5, 1'b0, 0);
        send(8'h3C, 1'b1, 0);
        idle(1);
        drain();

        // Single word held by a stalled consumer.
        rdy_mode = 2;
        @(posedge clk);
        #3;
        send(8'hFF, 1'b1, 0);
        idle(5);
        chk("stall_out_valid", int'(out_valid), 1);
        chk("stall_in_ready", int'(in_ready), 0);
        rdy_mode = 0;
        @(posedge clk);
        #3;
        @(posedge clk);
        #1;
        chk("release_out_valid", int'(out_valid), 0);
        chk("release_in_ready", int'(in_ready), 1);
        drain();

        // Forced close at MAX_WORDS, then limit reached together with in_last.
        for (int i = 0; i < MAXW; i++) send(8'h01, 1'b0, 0);
        for (int i = 0; i < MAXW; i++) send(8'h01, (i == MAXW - 1), 0);
        idle(1);
        drain();

        // Back-to-back frames with in_valid held high.
        send(8'h0F, 1'b1, 0);
        send(8'hF0, 1'b0, 0);
        send(8'h01, 1'b1, 0);
        idle(1);
        drain();

        // Reset after three accepted words discards the partial frame.
        send(8'h11, 1'b0, 0);
        send(8'h22, 1'b0, 0);
        send(8'h44, 1'b0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        m_acc = 8'h00;
        m_n   = 0;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        send(8'h80, 1'b1, 0);
        idle(1);
        drain();

        // Randomized frames, random gaps and random consumer back-pressure.
        rdy_mode = 1;
        for (int f = 0; f < 40; f++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int i = 0; i < len; i++) begin
                send(8'($urandom), (i == len - 1) && ($urandom_range(0, 3) != 0),
                     ($urandom_range(0, 3) == 0) ? 1 : 0);
            end
        end
        // Close any frame still open in the model.
        if (m_n != 0) send(8'($urandom), 1'b1, 0);
        idle(1);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
